restoring_div_ctrl: RTL and testbench

- Multi-cycle unsigned N-bit restoring divider controller.
- Sequences one shared (N+1)-bit ripple subtractor, one trial subtraction per clock, to produce quotient and remainder.
- Sits above the gate-level subtractor library as the first sequential consumer of the ripple subtract datapath; trades latency for area versus an unrolled array.

---
 rtl/restoring_div_ctrl_pkg.sv | 24 ++
 rtl/restoring_div_ctrl_sub.sv | 35 +++
 rtl/restoring_div_ctrl.sv | 145 ++++++++++++++
 tb/tb_restoring_div_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/restoring_div_ctrl_pkg.sv
// Shared definitions for the restoring divider controller.
//   state_t         : 2-bit FSM state encoding (IDLE / RUN / DONE)
//   div_cnt_width() : width of the iteration counter for an N-bit divider
package restoring_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold N-1; never narrower than one bit.
    function automatic int div_cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : restoring_div_ctrl_pkg

// File: rtl/restoring_div_ctrl_sub.sv
// Gate-level N-bit ripple-borrow subtractor: d = a - b.
// Ports:
//   a      : minuend (N bits)
//   b      : subtrahend (N bits)
//   d      : difference (N bits, modulo 2^N)
//   borrow : borrow out of the MSB (1 when a < b)
// Purely combinational; built from per-bit full-subtractor cells so no
// arithmetic operator is inferred.
module ripplenbit_sub #(
    parameter int N = 7
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] d,
    output logic         borrow
);

    logic [N:0] bchain_s;

    assign bchain_s[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            logic axb_s;
            assign axb_s         = a[i] ^ b[i];
            assign d[i]          = axb_s ^ bchain_s[i];
            // Borrow out when a<b at this bit, or equal bits with a borrow in.
            assign bchain_s[i+1] = (~a[i] & b[i]) | (~axb_s & bchain_s[i]);
        end
    endgenerate

    assign borrow = bchain_s[N];

endmodule : ripplenbit_sub

// File: rtl/restoring_div_ctrl.sv
// Multi-cycle unsigned restoring divider controller.
// One trial subtraction per clock through a shared (N+1)-bit ripple
// subtractor; N iterations per division.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : request, honoured only while ready=1
//   dividend, divisor  : operands, captured when start is accepted
//   ready              : high in IDLE
//   done               : one-cycle pulse, results valid
//   quotient,remainder : results, held until the next done pulse
//   div_by_zero        : set with done when the divisor was zero
module restoring_div_ctrl
    import restoring_div_ctrl_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = div_cnt_width(N);

    state_t            state_r, state_nxt_s;
    logic [N-1:0]      q_r, q_nxt_s;
    logic [N-1:0]      r_r, r_nxt_s;
    logic [N-1:0]      d_r, d_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [N-1:0]      quot_nxt_s, rem_nxt_s;
    logic              dbz_nxt_s;

    logic [N:0]        trial_s;
    logic [N:0]        sub_b_s;
    logic [N:0]        diff_s;
    logic              borrow_s;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial_s = {r_r, q_r[N-1]};
    assign sub_b_s = {1'b0, d_r};

    ripplenbit_sub #(
        .N (N + 1)
    ) u_sub (
        .a      (trial_s),
        .b      (sub_b_s),
        .d      (diff_s),
        .borrow (borrow_s)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s = state_r;
        q_nxt_s     = q_r;
        r_nxt_s     = r_r;
        d_nxt_s     = d_r;
        cnt_nxt_s   = cnt_r;
        quot_nxt_s  = quotient;
        rem_nxt_s   = remainder;
        dbz_nxt_s   = div_by_zero;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != {N{1'b0}}) begin
                        state_nxt_s = ST_RUN;
                        q_nxt_s     = dividend;
                        r_nxt_s     = {N{1'b0}};
                        d_nxt_s     = divisor;
                        cnt_nxt_s   = CNT_W'(N - 1);
                        dbz_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_DONE;
                        quot_nxt_s  = {N{1'b1}};
                        rem_nxt_s   = dividend;
                        dbz_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Restoring is just keeping the trial value: R < D always holds.
                if (!borrow_s) begin
                    r_nxt_s = diff_s[N-1:0];
                    q_nxt_s = {q_r[N-2:0], 1'b1};
                end else begin
                    r_nxt_s = trial_s[N-1:0];
                    q_nxt_s = {q_r[N-2:0], 1'b0};
                end
                if (cnt_r == {CNT_W{1'b0}}) begin
                    // Results are registered on entry so they are valid with done.
                    state_nxt_s = ST_DONE;
                    quot_nxt_s  = q_nxt_s;
                    rem_nxt_s   = r_nxt_s;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            q_r         <= {N{1'b0}};
            r_r         <= {N{1'b0}};
            d_r         <= {N{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            quotient    <= {N{1'b0}};
            remainder   <= {N{1'b0}};
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            q_r         <= q_nxt_s;
            r_r         <= r_nxt_s;
            d_r         <= d_nxt_s;
            cnt_r       <= cnt_nxt_s;
            quotient    <= quot_nxt_s;
            remainder   <= rem_nxt_s;
            div_by_zero <= dbz_nxt_s;
            ready       <= (state_nxt_s == ST_IDLE);
            done        <= (state_nxt_s == ST_DONE);
        end
    end

endmodule : restoring_div_ctrl

// File: tb/tb_restoring_div_ctrl.sv
// Directed testbench for restoring_div_ctrl (N=6).
module tb_restoring_div_ctrl;

    localparam int N = 6;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int errors;

    restoring_div_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division once ready; returns results and latency in cycles
    // (1 = done seen right after the accepting edge).
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic dz, output int lat);
        int w;
        w = 0;
        while (!ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout %0d/%0d: done=%0b required 1", a, b, done);
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = 6'd0; divisor = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 6'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%0b done=%0b q=%0d r=%0d dz=%0b required 1 0 0 0 0",
                     ready, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] q, r;
        logic dz;
        int lat;
        run_div(6'd45, 6'd7, q, r, dz, lat);
        checks++;
        if ({q, r, dz} !== {6'd6, 6'd3, 1'b0}) begin
            errors++;
            $display("FAIL div_45_7: q=%0d r=%0d dz=%0b required 6 3 0", q, r, dz);
        end
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL latency_45_7: got %0d required 7", lat);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_done: got %0b required 0", ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({ready, done} !== 2'b10) begin
            errors++;
            $display("FAIL ready_after_done: rdy=%0b done=%0b required 1 0", ready, done);
        end
    endtask

    task automatic test_edges();
        logic [N-1:0] a_t [3] = '{6'd63, 6'd5, 6'd63};
        logic [N-1:0] b_t [3] = '{6'd1, 6'd9, 6'd63};
        logic [N-1:0] q_t [3] = '{6'd63, 6'd0, 6'd1};
        logic [N-1:0] r_t [3] = '{6'd0, 6'd5, 6'd0};
        logic [N-1:0] q, r;
        logic dz;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_div(a_t[i], b_t[i], q, r, dz, lat);
            checks++;
            if ({q, r, dz} !== {q_t[i], r_t[i], 1'b0}) begin
                errors++;
                $display("FAIL edge_%0d_%0d: q=%0d r=%0d dz=%0b required %0d %0d 0",
                         a_t[i], b_t[i], q, r, dz, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [N-1:0] q, r;
        logic dz;
        int lat;
        run_div(6'd20, 6'd0, q, r, dz, lat);
        checks++;
        if ({q, r, dz} !== {6'd63, 6'd20, 1'b1}) begin
            errors++;
            $display("FAIL div0_20: q=%0d r=%0d dz=%0b required 63 20 1", q, r, dz);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL latency_div0: got %0d required 1", lat);
        end
        run_div(6'd20, 6'd3, q, r, dz, lat);
        checks++;
        if ({q, r, dz} !== {6'd6, 6'd2, 1'b0}) begin
            errors++;
            $display("FAIL div_20_3: q=%0d r=%0d dz=%0b required 6 2 0", q, r, dz);
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        logic [N-1:0] q_seen, r_seen;
        done_cnt = 0; q_seen = 6'd0; r_seen = 6'd0;
        while (!ready) begin @(posedge clk); #1; end
        @(negedge clk);
        dividend = 6'd45; divisor = 6'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        dividend = 6'd9; divisor = 6'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                done_cnt++;
                q_seen = quotient;
                r_seen = remainder;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d required 1", done_cnt);
        end
        checks++;
        if ({q_seen, r_seen} !== {6'd6, 6'd3}) begin
            errors++;
            $display("FAIL ignore_result: q=%0d r=%0d required 6 3", q_seen, r_seen);
        end
        checks++;
        if ({ready, quotient, remainder} !== {1'b1, 6'd6, 6'd3}) begin
            errors++;
            $display("FAIL ignore_hold: rdy=%0b q=%0d r=%0d required 1 6 3",
                     ready, quotient, remainder);
        end
    endtask

    task automatic test_mid_reset();
        int done_cnt;
        logic [N-1:0] q, r;
        logic dz;
        int lat;
        done_cnt = 0;
        @(negedge clk);
        dividend = 6'd45; divisor = 6'd7; start = 1'b1;
        @(posedge clk); #1;           // RUN cycle 1
        start = 1'b0;
        @(posedge clk); #1;           // RUN cycle 2
        @(posedge clk); #1;           // RUN cycle 3
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ready, done, quotient, remainder} !== {1'b1, 1'b0, 6'd0, 6'd0}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%0b done=%0b q=%0d r=%0d required 1 0 0 0",
                     ready, done, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d pulses required 0", done_cnt);
        end
        run_div(6'd17, 6'd4, q, r, dz, lat);
        checks++;
        if ({q, r, dz} !== {6'd4, 6'd1, 1'b0}) begin
            errors++;
            $display("FAIL div_17_4: q=%0d r=%0d dz=%0b required 4 1 0", q, r, dz);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] q, r, eq, er;
        logic dz, edz;
        int lat;
        int sweep_err;
        time t_prev, t_now;
        logic prev_norm;
        sweep_err = 0;
        prev_norm = 1'b0;
        t_prev = 0;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                run_div(6'(a), 6'(b), q, r, dz, lat);
                t_now = $time;
                if (b == 0) begin
                    eq = 6'd63; er = 6'(a); edz = 1'b1;
                end else begin
                    eq = 6'(a / b); er = 6'(a % b); edz = 1'b0;
                end
                checks++;
                if ({q, r, dz} !== {eq, er, edz}) begin
                    errors++;
                    sweep_err++;
                    if (sweep_err < 10)
                        $display("FAIL sweep_%0d_%0d: q=%0d r=%0d dz=%0b required %0d %0d %0b",
                                 a, b, q, r, dz, eq, er, edz);
                end
                if (prev_norm && b != 0) begin
                    checks++;
                    if (t_now - t_prev !== 80) begin
                        errors++;
                        sweep_err++;
                        if (sweep_err < 10)
                            $display("FAIL spacing_%0d_%0d: got %0t required 80", a, b, t_now - t_prev);
                    end
                end
                prev_norm = (b != 0);
                t_prev = t_now;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_edges();
        test_div_by_zero();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_restoring_div_ctrl
